// File: rtl/mem_access_unit.sv
// Initiator side of the word-addressed data-memory interface: turns byte-addressed
// byte/half/word loads and stores into word accesses, using read-modify-write for sub-word stores.
module mem_access_unit #(
    parameter int unsigned MEM_DEPTH = 64,
    parameter int unsigned IDX_W     = 6
) (
    input  logic        Clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        stall,
    output logic [31:0] mem_address,
    output logic [31:0] mem_writeData,
    output logic        mem_write,
    output logic        mem_read,
    input  logic [31:0] mem_readData
);

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_BAD  = 2'b11;

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    state_t      state;
    logic [1:0]  a_lane;
    logic [1:0]  a_size;
    logic [15:0] a_wdata;
    logic        a_unsigned;
    logic        a_write;

    logic        req_err;
    logic [7:0]  lane_byte;
    logic [15:0] lane_half;
    logic [31:0] load_data;
    logic [31:0] merge_data;

    // Request legality: alignment, size encoding and word-index range
    always_comb begin
        req_err = 1'b0;
        if (req_size == SZ_BAD)                               req_err = 1'b1;
        if (req_size == SZ_HALF && req_addr[0])               req_err = 1'b1;
        if (req_size == SZ_WORD && req_addr[1:0] != 2'b00)    req_err = 1'b1;
        if (req_addr[31:2] >= 30'(MEM_DEPTH))                 req_err = 1'b1;
    end

    // Lane extraction for loads and lane merge for sub-word stores
    always_comb begin
        case (a_lane)
            2'd0:    lane_byte = mem_readData[7:0];
            2'd1:    lane_byte = mem_readData[15:8];
            2'd2:    lane_byte = mem_readData[23:16];
            default: lane_byte = mem_readData[31:24];
        endcase
        lane_half = a_lane[1] ? mem_readData[31:16] : mem_readData[15:0];

        case (a_size)
            SZ_BYTE: load_data = a_unsigned ? {24'b0, lane_byte} : {{24{lane_byte[7]}}, lane_byte};
            SZ_HALF: load_data = a_unsigned ? {16'b0, lane_half} : {{16{lane_half[15]}}, lane_half};
            default: load_data = mem_readData;
        endcase

        merge_data = mem_readData;
        if (a_size == SZ_BYTE) begin
            case (a_lane)
                2'd0:    merge_data[7:0]   = a_wdata[7:0];
                2'd1:    merge_data[15:8]  = a_wdata[7:0];
                2'd2:    merge_data[23:16] = a_wdata[7:0];
                default: merge_data[31:24] = a_wdata[7:0];
            endcase
        end else if (a_lane[1]) begin
            merge_data[31:16] = a_wdata;
        end else begin
            merge_data[15:0] = a_wdata;
        end
    end

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            a_lane        <= 2'b00;
            a_size        <= SZ_WORD;
            a_wdata       <= 16'h0;
            a_unsigned    <= 1'b0;
            a_write       <= 1'b0;
            req_ready     <= 1'b1;
            rsp_valid     <= 1'b0;
            rsp_rdata     <= 32'h0;
            rsp_err       <= 1'b0;
            stall         <= 1'b0;
            mem_address   <= 32'h0;
            mem_writeData <= 32'h0;
            mem_write     <= 1'b0;
            mem_read      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        a_lane     <= req_addr[1:0];
                        a_size     <= req_size;
                        a_wdata    <= req_wdata[15:0];
                        a_unsigned <= req_unsigned;
                        a_write    <= req_write;
                        req_ready  <= 1'b0;
                        stall      <= 1'b1;
                        if (req_err) begin
                            state     <= DONE;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_rdata <= 32'h0;
                        end else begin
                            mem_address <= 32'(req_addr[IDX_W+1:2]);
                            if (req_write && req_size == SZ_WORD) begin
                                state         <= WRITE;
                                mem_write     <= 1'b1;
                                mem_writeData <= req_wdata;
                            end else begin
                                state    <= READ;
                                mem_read <= 1'b1;
                            end
                        end
                    end
                end
                READ: begin
                    mem_read <= 1'b0;
                    if (a_write) begin
                        state         <= WRITE;
                        mem_write     <= 1'b1;
                        mem_writeData <= merge_data;
                    end else begin
                        state     <= DONE;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b0;
                        rsp_rdata <= load_data;
                    end
                end
                WRITE: begin
                    state     <= DONE;
                    mem_write <= 1'b0;
                    rsp_valid <= 1'b1;
                    rsp_err   <= 1'b0;
                    rsp_rdata <= 32'h0;
                end
                default: begin
                    state     <= IDLE;
                    rsp_valid <= 1'b0;
                    rsp_err   <= 1'b0;
                    rsp_rdata <= 32'h0;
                    req_ready <= 1'b1;
                    stall     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a negedge-commit word memory model.
module tb_mem_access_unit;

    logic        Clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        stall;
    logic [31:0] mem_address;
    logic [31:0] mem_writeData;
    logic        mem_write;
    logic        mem_read;
    logic [31:0] mem_readData;

    logic [31:0] mem [64];

    int total = 0;
    int bad   = 0;

    logic [31:0] got_rdata;
    logic        got_err;
    int          lat, rd_cyc, wr_cyc;
    logic        overlap, busy_ready, busy_stall;

    mem_access_unit #(.MEM_DEPTH(64), .IDX_W(6)) dut (
        .Clk(Clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .stall(stall), .mem_address(mem_address),
        .mem_writeData(mem_writeData), .mem_write(mem_write), .mem_read(mem_read),
        .mem_readData(mem_readData)
    );

    always #5 Clk = ~Clk;

    assign mem_readData = mem[mem_address[5:0]];

    always @(negedge Clk) begin
        if (mem_write) mem[mem_address[5:0]] <= mem_writeData;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Issue one request, then scramble the inputs to show they were latched
    task automatic do_req(input logic w, input logic [1:0] sz, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wd);
        req_valid = 1'b1; req_write = w; req_size = sz; req_unsigned = uns;
        req_addr = addr; req_wdata = wd;
        @(posedge Clk); #1;
        req_valid = 1'b0; req_addr = 32'hFFFF_FFFC; req_wdata = 32'h5555_5555;
        req_size = 2'b10; req_unsigned = ~uns; req_write = ~w;
        lat = 0; rd_cyc = 0; wr_cyc = 0; overlap = 1'b0;
        busy_ready = req_ready; busy_stall = stall;
        while (!rsp_valid && lat < 8) begin
            rd_cyc += int'(mem_read);
            wr_cyc += int'(mem_write);
            overlap |= mem_read & mem_write;
            @(posedge Clk); #1;
            lat++;
        end
        check("rsp_valid", 32'(rsp_valid), 32'd1);
        got_rdata = rsp_rdata;
        got_err   = rsp_err;
        if (!got_err) check("mem_address", mem_address, 32'(addr[7:2]));
        @(posedge Clk); #1;
        check("rsp_pulse", 32'(rsp_valid), 32'd0);
    endtask

    task automatic load_case(input string tag, input logic [1:0] sz, input logic uns,
                             input logic [31:0] addr, input logic [31:0] exp);
        do_req(1'b0, sz, uns, addr, 32'h0);
        check(tag, got_rdata, exp);
        check({tag, "_err"}, 32'(got_err), 32'd0);
        check({tag, "_lat"}, 32'(lat), 32'd1);
        check({tag, "_rd"}, 32'(rd_cyc), 32'd1);
        check({tag, "_wr"}, 32'(wr_cyc), 32'd0);
    endtask

    task automatic err_case(input string tag, input logic w, input logic [1:0] sz,
                            input logic [31:0] addr);
        do_req(w, sz, 1'b0, addr, 32'h1234_5678);
        check({tag, "_err"}, 32'(got_err), 32'd1);
        check({tag, "_rdata"}, got_rdata, 32'h0);
        check({tag, "_lat"}, 32'(lat), 32'd0);
        check({tag, "_mem"}, 32'(rd_cyc + wr_cyc), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'hA500_0000 | 32'(i);
        mem[5] = 32'h80FF_1234;
        mem[8] = 32'h1122_3344;
        reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
        req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
        repeat (2) @(posedge Clk); #1;
        check("rst_ready", 32'(req_ready), 32'd1);
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_rsp", {30'b0, rsp_valid, rsp_err}, 32'd0);
        check("rst_mem", {30'b0, mem_read, mem_write}, 32'd0);
        check("rst_addr", mem_address, 32'h0);
        reset = 1'b0;
        @(posedge Clk); #1;

        // Loads from 0x80FF_1234
        load_case("lb_15_s", 2'b00, 1'b0, 32'h15, 32'h0000_0012);
        check("busy_ready", 32'(busy_ready), 32'd0);
        check("busy_stall", 32'(busy_stall), 32'd1);
        load_case("lb_16_s", 2'b00, 1'b0, 32'h16, 32'hFFFF_FFFF);
        load_case("lb_17_u", 2'b00, 1'b1, 32'h17, 32'h0000_0080);
        load_case("lb_17_s", 2'b00, 1'b0, 32'h17, 32'hFFFF_FF80);
        load_case("lh_16_u", 2'b01, 1'b1, 32'h16, 32'h0000_80FF);
        load_case("lh_16_s", 2'b01, 1'b0, 32'h16, 32'hFFFF_80FF);
        load_case("lh_14_s", 2'b01, 1'b0, 32'h14, 32'h0000_1234);

        // Sub-word stores take READ then WRITE
        do_req(1'b1, 2'b00, 1'b0, 32'h17, 32'h0000_00AB);
        check("sb_mem", mem[5], 32'hABFF_1234);
        check("sb_lat", 32'(lat), 32'd2);
        check("sb_rd", 32'(rd_cyc), 32'd1);
        check("sb_wr", 32'(wr_cyc), 32'd1);
        check("sb_ovl", 32'(overlap), 32'd0);
        check("sb_rdata", got_rdata, 32'h0);
        do_req(1'b1, 2'b01, 1'b0, 32'h14, 32'hFFFF_5678);
        check("sh_mem", mem[5], 32'hABFF_5678);
        check("sh_lat", 32'(lat), 32'd2);
        load_case("lw_14", 2'b10, 1'b0, 32'h14, 32'hABFF_5678);

        // Word store goes straight to WRITE
        do_req(1'b1, 2'b10, 1'b0, 32'h08, 32'hDEAD_BEEF);
        check("sw_mem", mem[2], 32'hDEAD_BEEF);
        check("sw_lat", 32'(lat), 32'd1);
        check("sw_rd", 32'(rd_cyc), 32'd0);
        check("sw_wr", 32'(wr_cyc), 32'd1);
        check("sw_ready", 32'(busy_ready), 32'd0);
        load_case("lw_08", 2'b10, 1'b0, 32'h08, 32'hDEAD_BEEF);

        // Errors
        err_case("e_lh_03", 1'b0, 2'b01, 32'h03);
        err_case("e_lw_102", 1'b0, 2'b10, 32'h102);
        err_case("e_lw_100", 1'b0, 2'b10, 32'h100);
        err_case("e_sz11", 1'b0, 2'b11, 32'h00);
        err_case("e_sb_100", 1'b1, 2'b00, 32'h100);
        check("e_mem5", mem[5], 32'hABFF_5678);

        // Reset while a sub-word store is in READ
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
        req_addr = 32'h21; req_wdata = 32'h99;
        @(posedge Clk); #1;
        req_valid = 1'b0;
        check("r6_in_read", 32'(mem_read), 32'd1);
        reset = 1'b1; #1;
        check("r6_mem", {30'b0, mem_read, mem_write}, 32'd0);
        check("r6_ready", 32'(req_ready), 32'd1);
        check("r6_stall", 32'(stall), 32'd0);
        check("r6_rsp", 32'(rsp_valid), 32'd0);
        @(posedge Clk); #1;
        reset = 1'b0;
        repeat (3) @(posedge Clk); #1;
        check("r6_nowrite", mem[8], 32'h1122_3344);
        load_case("r6_lw_20", 2'b10, 1'b0, 32'h20, 32'h1122_3344);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
